icap_reboot_seq: RTL

Wishbone master that generates the Spartan-3A MultiBoot/IPROG command sequence and writes it, one byte per transaction, into the ICAP Wishbone slave that sits directly downstream. Firmware writes a boot address and pulses `start`. The block then streams the dummy word, sync word, GENERAL register writes, REBOOT command and NOOP padding, and the FPGA reconfigures from the new SPI flash image. It replaces the firmware byte-banging loop and handles timeout and error reporting in hardware.

---
 rtl/icap_reboot_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/icap_reboot_seq.sv
// -----------------------------------------------------------------------------
// icap_reboot_seq
//
// Wishbone master that streams the Spartan-3A MultiBoot/IPROG command sequence
// into the downstream ICAP Wishbone slave, one byte per transaction. Firmware
// supplies a boot address and pulses start; the block sends dummy word, sync
// word, GENERAL register writes, the REBOOT command and NOOP padding, then
// reports done (or error if the slave stops acknowledging).
//
// Optional feature: define ICAP_REBOOT_FALLBACK_EN to add the fallback_addr
// port and the GENERAL3/GENERAL4 writes (golden image address), growing the
// sequence from 20 to 28 bytes.
//
// Parameters:
//   READ_OPCODE  SPI read opcode placed in the upper byte of GENERAL2/GENERAL4
//   BITSWAP      1: reverse bit order of each byte on dat_o[7:0] (ICAP D0=MSB)
//   ACK_TIMEOUT  clocks allowed in REQ without ack before aborting (2..255)
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             one-cycle request, honoured only in IDLE/DONE/ERR
//   boot_addr         24-bit flash address of the image to boot
//   fallback_addr     24-bit golden image address (fallback build only)
//   busy              high from accepted start until DONE or ERR
//   done              one-cycle pulse after the final byte's ack
//   error             set on ack timeout, held until next accepted start
//   cyc_o/stb_o/we_o  Wishbone strobes (all identical)
//   dat_o             {24'h0, sequence byte}
//   ack_i             Wishbone ack from the ICAP slave
// -----------------------------------------------------------------------------
module icap_reboot_seq #(
    parameter logic [7:0]  READ_OPCODE = 8'h0B,
    parameter bit          BITSWAP     = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] boot_addr,
`ifdef ICAP_REBOOT_FALLBACK_EN
    input  logic [23:0] fallback_addr,
`endif
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] dat_o,
    input  logic        ack_i
);

`ifdef ICAP_REBOOT_FALLBACK_EN
    localparam logic [4:0] LAST_IDX = 5'd27;
`else
    localparam logic [4:0] LAST_IDX = 5'd19;
`endif
    // Count value on which the ACK_TIMEOUT-th REQ clock completes.
    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [7:0]  cnt_q;
    logic [23:0] boot_q;
`ifdef ICAP_REBOOT_FALLBACK_EN
    logic [23:0] fb_q;
`endif
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        stb_q;
    logic [7:0]  dat_q;

    logic [4:0]  rom_idx;
    logic [15:0] rom_word;
    logic [7:0]  rom_sel;
    logic [7:0]  rom_swp;
    logic [7:0]  rom_byte;

    // Byte ROM. dat_q is loaded on entry to REQ: from GAP the index was
    // already advanced on the ack edge; on start the index is 0, and word 0
    // is the address-independent dummy word, so the not-yet-latched
    // addresses do not matter.
    always_comb begin
        rom_idx  = (state_q == S_GAP) ? idx_q : 5'd0;
        rom_word = 16'h0000;
        case (rom_idx[4:1])
            4'd0:  rom_word = 16'hFFFF;                    // dummy
            4'd1:  rom_word = 16'hAA99;                    // sync
            4'd2:  rom_word = 16'h3261;                    // GENERAL1 write
            4'd3:  rom_word = boot_q[15:0];
            4'd4:  rom_word = 16'h3281;                    // GENERAL2 write
            4'd5:  rom_word = {READ_OPCODE, boot_q[23:16]};
`ifdef ICAP_REBOOT_FALLBACK_EN
            4'd6:  rom_word = 16'h32A1;                    // GENERAL3 write
            4'd7:  rom_word = fb_q[15:0];
            4'd8:  rom_word = 16'h32C1;                    // GENERAL4 write
            4'd9:  rom_word = {READ_OPCODE, fb_q[23:16]};
            4'd10: rom_word = 16'h30A1;                    // CMD write
            4'd11: rom_word = 16'h000E;                    // REBOOT
            4'd12: rom_word = 16'h2000;                    // NOOP
            4'd13: rom_word = 16'h2000;                    // NOOP
`else
            4'd6:  rom_word = 16'h30A1;                    // CMD write
            4'd7:  rom_word = 16'h000E;                    // REBOOT
            4'd8:  rom_word = 16'h2000;                    // NOOP
            4'd9:  rom_word = 16'h2000;                    // NOOP
`endif
            default: rom_word = 16'h0000;
        endcase
        // High byte of each word goes first.
        rom_sel = rom_idx[0] ? rom_word[7:0] : rom_word[15:8];
        rom_swp = '0;
        for (int i = 0; i < 8; i++) begin
            rom_swp[i] = rom_sel[7-i];
        end
        rom_byte = BITSWAP ? rom_swp : rom_sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            boot_q  <= '0;
`ifdef ICAP_REBOOT_FALLBACK_EN
            fb_q    <= '0;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            stb_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        boot_q  <= boot_addr;
`ifdef ICAP_REBOOT_FALLBACK_EN
                        fb_q    <= fallback_addr;
`endif
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        stb_q   <= 1'b1;
                        dat_q   <= rom_byte;
                        state_q <= S_REQ;
                    end else if (state_q == S_DONE) begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // An ack on the final allowed clock still wins over timeout.
                    if (ack_i) begin
                        stb_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            state_q <= S_GAP;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    cnt_q   <= '0;
                    stb_q   <= 1'b1;
                    dat_q   <= rom_byte;
                    state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign cyc_o = stb_q;
    assign stb_o = stb_q;
    assign we_o  = stb_q;
    assign dat_o = {24'h000000, dat_q};

endmodule
